ucsbece154_icache_lru: RTL and testbench
========================================

Name: ucsbece154_icache_lru

Overview:
Next-generation instruction cache between the fetch stage and the SDRAM controller. It is set-associative and fully parametrised, with true-LRU replacement, early restart on refill and a global flush. It also provides hit/miss performance counters. The core-side and memory-side handshakes match the existing fetch and SDRAM-controller interfaces.

Parameters:
NUM_SETS, 8, number of sets (power of 2, >=2)
NUM_WAYS, 4, associativity (power of 2, >=2)
BLOCK_WORDS, 4, 32-bit words per block (power of 2, >=2)
CNT_WIDTH, 32, width of the performance counters

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
ReadEnable  input  1  fetch request, sampled only when Busy=0
ReadAddress  input  32  byte address; bits [1:0] ignored
Flush  input  1  invalidate all lines
Instruction  output  32  fetched word, valid when Ready=1
Ready  output  1  one-cycle pulse, Instruction valid
Busy  output  1  refill in progress; requests ignored
MemReadAddress  output  32  block-aligned refill address
MemReadRequest  output  1  held high for the whole refill
MemDataIn  input  32  refill beat data
MemDataReady  input  1  one beat valid this cycle
HitCount  output  CNT_WIDTH  completed hits, wraps modulo 2^CNT_WIDTH
MissCount  output  CNT_WIDTH  accepted misses, wraps

Behaviour:
- Address split: offset = 2 + log2(BLOCK_WORDS) bits; set = next log2(NUM_SETS) bits; tag = remaining upper bits.
- Reset (async): valid, Ready, Busy, MemReadRequest, MemReadAddress, Instruction, counters all 0. LRU age of way i is set to i in every set. Reset asserted mid-refill aborts it immediately; MemReadRequest drops asynchronously.
- States: IDLE and REFILL. Busy = (state==REFILL).
- IDLE, Flush=1: all valid bits clear at the edge; any ReadEnable that cycle is dropped (no Ready, no counter change).
- IDLE, ReadEnable=1, hit (combinational tag compare against all ways):
  - Ready=1 and Instruction=data from the next edge, i.e. 1-cycle latency.
  - HitCount+1; LRU updated for the hit way.
  - Back-to-back hits sustain one word per cycle.
- IDLE, ReadEnable=1, miss:
  - At the edge: latch the address; MemReadAddress = block-aligned address; MemReadRequest=1.
  - State goes to REFILL; MissCount+1.
  - Victim = lowest-index invalid way, else the way with age NUM_WAYS-1. The victim's valid bit is cleared at this edge.
- REFILL:
  - Beats arrive in ascending word order, possibly non-consecutive; only cycles with MemDataReady=1 count.
  - Beat k is written to victim word k.
  - When k equals the latched word offset: Instruction=MemDataIn and Ready=1 next cycle (early restart).
  - On beat BLOCK_WORDS-1: tag is written; valid is set unless a flush is pending; LRU is updated for the victim; MemReadRequest=0, Busy=0 and state returns to IDLE, all at that edge.
  - ReadEnable is ignored throughout REFILL; a new request is accepted from the cycle after Busy falls.
- Flush during REFILL: all valid bits clear immediately and flush_pending is set. The refill still completes and delivers its word with Ready. The refilled line stays invalid; flush_pending clears on completion.
- LRU per set, log2(NUM_WAYS)-bit age per way, 0 = MRU. On access to way w with age a: ways with age < a increment, w becomes 0. Ages always form a permutation of 0..NUM_WAYS-1.
- MemDataReady in IDLE is ignored.
- Ready never asserts in the same cycle as the request; it is at most one pulse per request.

Test Plan:
(Default parameters: 4-bit offset, 3-bit set, 25-bit tag.)
1. Cold read 0x48, beats 0x11,0x22,0x33,0x44 -> MemReadAddress=0x40, MemReadRequest held for 4 beats; Ready with Instruction=0x33 the cycle after beat 2; Busy=0 after beat 3; MissCount=1.
2. Then read 0x4C -> Ready next cycle, Instruction=0x44, MemReadRequest stays 0, HitCount=1.
3. LRU: fill set 0 with blocks 0x000,0x080,0x100,0x180; hit 0x000; miss 0x200 -> replaces 0x080's way; read 0x080 misses; read 0x000 hits.
4. After scenario 2, pulse Flush one cycle, then read 0x48 -> miss, MemReadRequest=1, MissCount=2, HitCount unchanged.
5. Flush asserted between beats 1 and 2 of a refill for 0x44 -> Ready with word 1 still occurs; re-read 0x44 misses.
6. Reset asserted after beat 1 -> Busy, MemReadRequest, Ready and counters are 0 immediately; after release, read 0x48 misses.

Source files
------------

// File: rtl/ucsbece154_icache_lru.sv
`default_nettype none
// ============================================================================
// Module : ucsbece154_icache_lru
// Set-associative instruction cache, true-LRU, early restart, global flush,
// hit/miss counters.
// Rev    : 1.0
// ============================================================================
module ucsbece154_icache_lru #(
  parameter int NUM_SETS    = 8,
  parameter int NUM_WAYS    = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 ReadEnable,
  input  logic [31:0]          ReadAddress,
  input  logic                 Flush,
  output logic [31:0]          Instruction,
  output logic                 Ready,
  output logic                 Busy,
  output logic [31:0]          MemReadAddress,
  output logic                 MemReadRequest,
  input  logic [31:0]          MemDataIn,
  input  logic                 MemDataReady,
  output logic [CNT_WIDTH-1:0] HitCount,
  output logic [CNT_WIDTH-1:0] MissCount
);
  localparam int c_WORD_W = $clog2(BLOCK_WORDS);
  localparam int c_OFF_W  = 2 + c_WORD_W;
  localparam int c_SET_W  = $clog2(NUM_SETS);
  localparam int c_TAG_W  = 32 - c_OFF_W - c_SET_W;
  localparam int c_AGE_W  = $clog2(NUM_WAYS);
  localparam logic [c_AGE_W-1:0]  c_AGE_MAX   = c_AGE_W'(NUM_WAYS - 1);
  localparam logic [c_WORD_W-1:0] c_LAST_BEAT = c_WORD_W'(BLOCK_WORDS - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_REFILL = 1'b1} state_t;
  state_t r_state, w_state_next;

  logic [31:0]        r_data [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
  logic [c_TAG_W-1:0] r_tag  [NUM_SETS][NUM_WAYS];
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]              r_valid;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][c_AGE_W-1:0] r_age;

  logic [c_TAG_W-1:0]  r_rtag;
  logic [c_SET_W-1:0]  r_rset;
  logic [c_WORD_W-1:0] r_rword;
  logic [c_WORD_W-1:0] r_beat;
  logic [c_AGE_W-1:0]  r_victim;
  logic                r_flush_pending;

  logic [c_WORD_W-1:0] w_word;
  logic [c_SET_W-1:0]  w_set;
  logic [c_TAG_W-1:0]  w_tag;
  logic                w_unused;
  logic                w_hit;
  logic [c_AGE_W-1:0]  w_hit_way;
  logic [c_AGE_W-1:0]  w_victim;
  logic                w_found;
  logic                w_hit_acc, w_miss_acc, w_beat, w_last;
  logic                w_lru_upd;
  logic [c_SET_W-1:0]  w_lru_set;
  logic [c_AGE_W-1:0]  w_lru_way;
  logic [c_AGE_W-1:0]  w_lru_age;

  assign w_word   = ReadAddress[c_OFF_W-1:2];
  assign w_set    = ReadAddress[c_OFF_W+c_SET_W-1:c_OFF_W];
  assign w_tag    = ReadAddress[31:c_OFF_W+c_SET_W];
  assign w_unused = ^ReadAddress[1:0];
  assign Busy     = (r_state == S_REFILL);

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[w_set][w] && (r_tag[w_set][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = c_AGE_W'(w);
      end
    end
  end

  // Lowest-index invalid way wins; otherwise the least recently used way.
  always_comb begin
    w_victim = '0;
    w_found  = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_age[w_set][w] == c_AGE_MAX) w_victim = c_AGE_W'(w);
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!w_found && !r_valid[w_set][w]) begin
        w_victim = c_AGE_W'(w);
        w_found  = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_hit_acc    = 1'b0;
    w_miss_acc   = 1'b0;
    w_beat       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ReadEnable && !Flush) begin
          if (w_hit) begin
            w_hit_acc = 1'b1;
          end else begin
            w_miss_acc   = 1'b1;
            w_state_next = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        if (MemDataReady) begin
          w_beat = 1'b1;
          if (r_beat == c_LAST_BEAT) begin
            w_last       = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_lru_upd = w_hit_acc | w_last;
  assign w_lru_set = w_hit_acc ? w_set : r_rset;
  assign w_lru_way = w_hit_acc ? w_hit_way : r_victim;
  assign w_lru_age = r_age[w_lru_set][w_lru_way];

  always_ff @(posedge Clk) begin
    if (w_beat) r_data[r_rset][r_victim][r_beat] <= MemDataIn;
    if (w_last) r_tag[r_rset][r_victim] <= r_rtag;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_valid         <= '0;
      Ready           <= 1'b0;
      Instruction     <= '0;
      MemReadRequest  <= 1'b0;
      MemReadAddress  <= '0;
      HitCount        <= '0;
      MissCount       <= '0;
      r_rtag          <= '0;
      r_rset          <= '0;
      r_rword         <= '0;
      r_beat          <= '0;
      r_victim        <= '0;
      r_flush_pending <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) r_age[s][w] <= c_AGE_W'(w);
      end
    end else begin
      Ready <= 1'b0;
      if (w_hit_acc) begin
        Ready       <= 1'b1;
        Instruction <= r_data[w_set][w_hit_way][w_word];
        HitCount    <= HitCount + CNT_WIDTH'(1);
      end
      if (w_miss_acc) begin
        r_rtag                  <= w_tag;
        r_rset                  <= w_set;
        r_rword                 <= w_word;
        r_victim                <= w_victim;
        r_beat                  <= '0;
        MemReadAddress          <= {ReadAddress[31:c_OFF_W], c_OFF_W'(0)};
        MemReadRequest          <= 1'b1;
        MissCount               <= MissCount + CNT_WIDTH'(1);
        r_valid[w_set][w_victim] <= 1'b0;
      end
      if (w_beat) begin
        r_beat <= r_beat + c_WORD_W'(1);
        if (r_beat == r_rword) begin
          Ready       <= 1'b1;
          Instruction <= MemDataIn;
        end
      end
      if (w_last) begin
        MemReadRequest  <= 1'b0;
        r_flush_pending <= 1'b0;
        if (!r_flush_pending && !Flush) r_valid[r_rset][r_victim] <= 1'b1;
      end else if (Flush && (r_state == S_REFILL)) begin
        r_flush_pending <= 1'b1;
      end
      // Flush overrides any valid-bit update made in the same cycle.
      if (Flush) r_valid <= '0;
      if (w_lru_upd) begin
        for (int i = 0; i < NUM_WAYS; i++) begin
          if (c_AGE_W'(i) == w_lru_way)
            r_age[w_lru_set][i] <= '0;
          else if (r_age[w_lru_set][i] < w_lru_age)
            r_age[w_lru_set][i] <= r_age[w_lru_set][i] + c_AGE_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154_icache_lru.sv
`default_nettype none
// ============================================================================
// Module : tb_ucsbece154_icache_lru
// Directed + randomized bench with a recency-list reference model.
// Rev    : 1.0
// ============================================================================
module tb_ucsbece154_icache_lru;
  localparam int NUM_SETS = 8, NUM_WAYS = 4, BLOCK_WORDS = 4, CNT_WIDTH = 32;

  logic        Clk = 1'b0;
  logic        Reset, ReadEnable, Flush, MemDataReady;
  logic [31:0] ReadAddress, MemDataIn;
  logic [31:0] Instruction, MemReadAddress;
  logic        Ready, Busy, MemReadRequest;
  logic [CNT_WIDTH-1:0] HitCount, MissCount;

  ucsbece154_icache_lru #(
    .NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS),
    .BLOCK_WORDS(BLOCK_WORDS), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .Clk(Clk), .Reset(Reset), .ReadEnable(ReadEnable), .ReadAddress(ReadAddress),
    .Flush(Flush), .Instruction(Instruction), .Ready(Ready), .Busy(Busy),
    .MemReadAddress(MemReadAddress), .MemReadRequest(MemReadRequest),
    .MemDataIn(MemDataIn), .MemDataReady(MemDataReady),
    .HitCount(HitCount), .MissCount(MissCount)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Model: per-set way contents plus a recency list of way numbers (MRU first).
  bit          mv [NUM_SETS][NUM_WAYS];
  logic [31:0] mt [NUM_SETS][NUM_WAYS];
  int          rec [NUM_SETS][$];
  int          exp_hits, exp_misses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (wa[31:4] == 28'h4) return 32'h11 * (32'(wa[3:2]) + 32'd1);
    return wa * 32'h9E3779B1 + 32'h01234567;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NUM_SETS; s++) begin
      rec[s].delete();
      for (int w = 0; w < NUM_WAYS; w++) begin
        mv[s][w] = 1'b0;
        mt[s][w] = '0;
        rec[s].push_back(w);
      end
    end
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic model_touch(input int s, input int w);
    for (int i = 0; i < rec[s].size(); i++) begin
      if (rec[s][i] == w) begin
        rec[s].delete(i);
        break;
      end
    end
    rec[s].push_front(w);
  endtask

  task automatic model_flush();
    for (int s = 0; s < NUM_SETS; s++)
      for (int w = 0; w < NUM_WAYS; w++) mv[s][w] = 1'b0;
  endtask

  task automatic do_flush(input bit with_re, input logic [31:0] addr);
    @(negedge Clk);
    Flush = 1'b1; ReadEnable = with_re; ReadAddress = addr;
    @(posedge Clk); #1;
    Flush = 1'b0; ReadEnable = 1'b0;
    model_flush();
    check("flush_ready", Ready, 0);
    check("flush_busy", Busy, 0);
    check("flush_hits", HitCount, exp_hits);
    check("flush_misses", MissCount, exp_misses);
  endtask

  task automatic do_read(input logic [31:0] addr, input int flush_beat, input int reset_beat);
    int s, wo, hw, v, gaps;
    bit hit, pend;
    logic [31:0] blk;
    blk = addr & 32'hFFFF_FFF0;
    s   = int'(addr[6:4]);
    wo  = int'(addr[3:2]);
    hit = 1'b0; hw = 0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (mv[s][w] && mt[s][w] == blk) begin hit = 1'b1; hw = w; end

    @(negedge Clk);
    ReadEnable = 1'b1; ReadAddress = addr;
    MemDataReady = 1'($urandom % 2); MemDataIn = $urandom;
    @(posedge Clk); #1;
    ReadEnable = 1'b0; MemDataReady = 1'b0;

    if (hit) begin
      exp_hits++;
      model_touch(s, hw);
      check("hit_ready", Ready, 1);
      check("hit_instr", Instruction, memw(addr));
      check("hit_count", HitCount, exp_hits);
      check("hit_busy", Busy, 0);
      check("hit_memreq", MemReadRequest, 0);
      return;
    end

    v = rec[s][rec[s].size() - 1];
    for (int w = NUM_WAYS - 1; w >= 0; w--) if (!mv[s][w]) v = w;
    mv[s][v] = 1'b0;
    exp_misses++;
    pend = 1'b0;
    check("miss_ready", Ready, 0);
    check("miss_busy", Busy, 1);
    check("miss_memreq", MemReadRequest, 1);
    check("miss_addr", MemReadAddress, blk);
    check("miss_count", MissCount, exp_misses);

    for (int k = 0; k < BLOCK_WORDS; k++) begin
      if (k == reset_beat) begin
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("rst_busy", Busy, 0);
        check("rst_memreq", MemReadRequest, 0);
        check("rst_ready", Ready, 0);
        check("rst_hits", HitCount, 0);
        check("rst_misses", MissCount, 0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
        return;
      end
      gaps = $urandom_range(0, 2);
      if (k == flush_beat && gaps == 0) gaps = 1;
      for (int g = 0; g < gaps; g++) begin
        @(negedge Clk);
        MemDataReady = 1'b0; MemDataIn = $urandom;
        Flush = (k == flush_beat && g == 0);
        ReadEnable = Flush ? 1'b0 : 1'($urandom % 2);
        ReadAddress = $urandom & 32'h0000_03FC;
        @(posedge Clk); #1;
        if (Flush) begin model_flush(); pend = 1'b1; end
        Flush = 1'b0; ReadEnable = 1'b0;
        check("gap_ready", Ready, 0);
        check("gap_busy", Busy, 1);
        check("gap_memreq", MemReadRequest, 1);
      end
      @(negedge Clk);
      MemDataReady = 1'b1; MemDataIn = memw(blk + 32'(4 * k));
      ReadEnable = 1'($urandom % 2); ReadAddress = $urandom & 32'h0000_03FC;
      @(posedge Clk); #1;
      MemDataReady = 1'b0; ReadEnable = 1'b0;
      check("beat_ready", Ready, (k == wo));
      if (k == wo) check("beat_instr", Instruction, memw(addr));
      check("beat_busy", Busy, (k != BLOCK_WORDS - 1));
      check("beat_memreq", MemReadRequest, (k != BLOCK_WORDS - 1));
    end
    mt[s][v] = blk;
    if (!pend) mv[s][v] = 1'b1;
    model_touch(s, v);
    check("done_hits", HitCount, exp_hits);

    @(negedge Clk);
    MemDataReady = 1'($urandom % 2); MemDataIn = $urandom;
    @(posedge Clk); #1;
    MemDataReady = 1'b0;
    check("post_ready", Ready, 0);
    check("post_busy", Busy, 0);
    check("post_misses", MissCount, exp_misses);
  endtask

  initial begin
    Reset = 1'b1; ReadEnable = 1'b0; ReadAddress = '0; Flush = 1'b0;
    MemDataReady = 1'b0; MemDataIn = '0;
    model_reset();
    #3;
    check("init_ready", Ready, 0);
    check("init_busy", Busy, 0);
    check("init_memreq", MemReadRequest, 0);
    check("init_memaddr", MemReadAddress, 0);
    check("init_instr", Instruction, 0);
    check("init_hits", HitCount, 0);
    check("init_misses", MissCount, 0);
    @(negedge Clk);
    Reset = 1'b0;

    // Cold miss with early restart, then a hit in the same block.
    do_read(32'h48, -1, -1);
    do_read(32'h4C, -1, -1);
    // Global flush (with a dropped request), then re-miss.
    do_flush(1'b1, 32'h48);
    do_read(32'h48, -1, -1);
    // LRU replacement in set 0.
    do_read(32'h000, -1, -1);
    do_read(32'h080, -1, -1);
    do_read(32'h100, -1, -1);
    do_read(32'h180, -1, -1);
    do_read(32'h000, -1, -1);
    do_read(32'h200, -1, -1);
    do_read(32'h080, -1, -1);
    do_read(32'h000, -1, -1);
    // Flush during a refill, then re-read misses.
    do_read(32'h44, 2, -1);
    do_read(32'h44, -1, -1);
    // Reset in the middle of a refill.
    do_read(32'h48, -1, 2);
    do_read(32'h48, -1, -1);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 5)) << 7) | (32'($urandom_range(0, 7)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 19) == 0)
        do_flush(1'($urandom % 2), a);
      else if ($urandom_range(0, 9) == 0)
        do_read(a, $urandom_range(0, 3), -1);
      else
        do_read(a, -1, -1);
    end
    check("final_hits", HitCount, exp_hits);
    check("final_misses", MissCount, exp_misses);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
